reg_share_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for one shared DATA_W-bit register built from reset D flip-flops.
- N_REQ requesters compete for write access. The block grants one requester at a time and loads that requester's data lane into the register.
- It signals completion with a registered ack pulse.
- Sits between requester logic and the shared storage element; q is the register output seen by all consumers.

---
 rtl/reg_share_pkg.sv | 19 +
 rtl/reg_share_arbiter_rr_pick.sv | 39 +++
 rtl/reg_share_arbiter.sv | 121 ++++++++++++
 tb/tb_reg_share_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_share_pkg.sv
// Shared types and defaults for the shared-register round-robin arbiter.
// Consumed by rr_pick and reg_share_arbiter.
package reg_share_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam int DEF_N_REQ    = 4;
   localparam int DEF_DATA_W   = 8;
   localparam int DEF_HOLD_MAX = 4;

   // Width of an index into n requesters, never below one bit.
   function automatic int idx_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reg_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping to 0.
module rr_pick
   import reg_share_pkg::*;
#(
   parameter int  N_REQ = DEF_N_REQ,
   localparam int IDX_W = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             valid,
   output logic [IDX_W-1:0] winner,
   output logic [N_REQ-1:0] onehot
);

   int               scan_idx;
   logic [IDX_W-1:0] cand;

   // NOTE: every output gets a default before the loop, so no path through the block infers a latch.
   always_comb begin
      valid    = 1'b0;
      winner   = '0;
      onehot   = '0;
      scan_idx = 0;
      cand     = '0;
      // Scan farthest-first so the candidate closest to ptr is written last and wins.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         scan_idx = int'(ptr) + k;
         if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
         cand = IDX_W'(scan_idx);
         if (req[cand]) begin
            valid        = 1'b1;
            winner       = cand;
            onehot       = '0;
            onehot[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter loading one requester's lane into a shared register, with ack pulse.
// Define ARB_HOLD_EN to let an owner make up to HOLD_MAX back-to-back writes per grant.
module reg_share_arbiter
   import reg_share_pkg::*;
#(
   parameter int  N_REQ    = DEF_N_REQ,
   parameter int  DATA_W   = DEF_DATA_W,
   parameter int  HOLD_MAX = DEF_HOLD_MAX,
   localparam int IDX_W    = idx_width(N_REQ)
) (
   input  logic                    ck,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] wdata,
   output logic [N_REQ-1:0]        gnt,
   output logic [IDX_W-1:0]        owner,
   output logic                    busy,
   output logic                    ack,
   output logic [DATA_W-1:0]       q
);

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   ptr, ptr_nxt, owner_nxt;
   logic [N_REQ-1:0]   gnt_nxt;
   logic               ack_nxt;
   logic [DATA_W-1:0]  q_nxt;
   logic [DATA_W-1:0]  lane [N_REQ];
   logic               owner_req;
   logic               pick_valid;
   logic [IDX_W-1:0]   pick_idx;
   logic [N_REQ-1:0]   pick_onehot;
`ifdef ARB_HOLD_EN
   logic [3:0]         cnt, cnt_nxt;
`endif

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req    (req),
      .ptr    (ptr),
      .valid  (pick_valid),
      .winner (pick_idx),
      .onehot (pick_onehot)
   );

   always_comb begin
      for (int i = 0; i < N_REQ; i++) lane[i] = wdata[i*DATA_W +: DATA_W];
   end

   // NOTE: state and datapath flops use <= only; the comb blocks below use = only.
   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         ptr   <= '0;
         owner <= '0;
         gnt   <= '0;
         ack   <= 1'b0;
         q     <= '0;
`ifdef ARB_HOLD_EN
         cnt   <= '0;
`endif
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         owner <= owner_nxt;
         gnt   <= gnt_nxt;
         ack   <= ack_nxt;
         q     <= q_nxt;
`ifdef ARB_HOLD_EN
         cnt   <= cnt_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      owner_nxt = owner;
      gnt_nxt   = gnt;
      ack_nxt   = 1'b0;
      q_nxt     = q;
      owner_req = req[owner];
`ifdef ARB_HOLD_EN
      cnt_nxt   = cnt;
`endif
      case (state)
         ST_IDLE: begin
            if (pick_valid) begin
               state_nxt = ST_GRANT;
               gnt_nxt   = pick_onehot;
               owner_nxt = pick_idx;
               ptr_nxt   = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
`ifdef ARB_HOLD_EN
               cnt_nxt   = '0;
`endif
            end
         end
         ST_GRANT: begin
            // A dropped owner request cancels the write: q holds and no ack.
            if (owner_req) begin
               q_nxt   = lane[owner];
               ack_nxt = 1'b1;
            end
`ifdef ARB_HOLD_EN
            if (owner_req) cnt_nxt = cnt + 4'd1;
            if (!(owner_req && (({1'b0, cnt} + 5'd1) < 5'(HOLD_MAX)))) begin
               state_nxt = ST_IDLE;
               gnt_nxt   = '0;
            end
`else
            state_nxt = ST_IDLE;
            gnt_nxt   = '0;
`endif
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == ST_GRANT);
   end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter: expected writes are queued as stimulus is driven
// and popped whenever ack is seen. Build with ARB_HOLD_EN for the hold scenario.
module tb_reg_share_arbiter;

   typedef struct {
      int         owner;
      logic [7:0] data;
   } exp_t;

   logic        ck    = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req   = 4'b1111;
   logic [31:0] wdata = '0;
   logic [3:0]  gnt;
   logic [1:0]  owner;
   logic        busy;
   logic        ack;
   logic [7:0]  q;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;

   reg_share_arbiter #(.N_REQ(4), .DATA_W(8), .HOLD_MAX(3)) dut (
      .ck    (ck),
      .reset (reset),
      .req   (req),
      .wdata (wdata),
      .gnt   (gnt),
      .owner (owner),
      .busy  (busy),
      .ack   (ack),
      .q     (q)
   );

   always #10 ck = ~ck;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge ck);
      #1;
   endtask

   task automatic set_lane(input int i, input logic [7:0] v);
      wdata[i*8 +: 8] = v;
   endtask

   task automatic push(input int o, input logic [7:0] d);
      exp_t e;
      e.owner = o;
      e.data  = d;
      exp_q.push_back(e);
   endtask

   // Scoreboard: every ack must match the oldest queued write.
   always @(negedge ck) begin
      if (!reset && ack === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("ack_unexpected", 32'(ack), 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("ack_q", 32'(q), 32'(mon_e.data));
            check("ack_owner", 32'(owner), mon_e.owner);
         end
      end
   end

   initial begin
      int exp_own[5] = '{0, 1, 2, 3, 0};

      // Reset held with all requests active.
      repeat (4) step();
      check("rst_q", q, 0);
      check("rst_gnt", gnt, 0);
      check("rst_ack", ack, 0);
      check("rst_busy", busy, 0);
      check("rst_owner", owner, 0);
      @(posedge ck);
      #5;
      req   = 4'b0000;
      reset = 1'b0;
      step();
      check("idle_busy", busy, 0);
      check("idle_gnt", gnt, 0);

`ifdef ARB_HOLD_EN
      // Hold: lane0 gets three back-to-back writes, then lane1 is granted.
      req = 4'b0011;
      set_lane(0, 8'h11);
      set_lane(1, 8'h22);
      push(0, 8'h11);
      push(0, 8'h11);
      push(0, 8'h11);
      push(1, 8'h22);
      step();
      check("hold_gnt0", gnt, 4'b0001);
      check("hold_ack_pre", ack, 0);
      for (int i = 0; i < 2; i++) begin
         step();
         check("hold_stay_gnt", gnt, 4'b0001);
         check("hold_stay_busy", busy, 1);
         check("hold_stay_ack", ack, 1);
         check("hold_stay_q", q, 8'h11);
      end
      step();
      check("hold_exit_gnt", gnt, 0);
      check("hold_exit_ack", ack, 1);
      check("hold_exit_q", q, 8'h11);
      req = 4'b0010;
      step();
      check("hold_gnt1", gnt, 4'b0010);
      check("hold_owner1", owner, 1);
      check("hold_gap_ack", ack, 0);
      step();
      check("hold_q1", q, 8'h22);
      check("hold_ack1", ack, 1);
      req = 4'b0000;
      step();
      check("hold_drop_ack", ack, 0);
      check("hold_drop_busy", busy, 0);
      check("hold_drop_q", q, 8'h22);
`else
      // Round-robin fairness with every request held.
      req = 4'b1111;
      for (int i = 0; i < 4; i++) set_lane(i, 8'((i + 1) * 16));
      for (int i = 0; i < 5; i++) push(exp_own[i], 8'((exp_own[i] + 1) * 16));
      for (int i = 0; i < 5; i++) begin
         step();
         check("rr_gnt", gnt, 32'(1) << exp_own[i]);
         check("rr_owner", owner, exp_own[i]);
         check("rr_busy", busy, 1);
         step();
         check("rr_gnt_off", gnt, 0);
         check("rr_q", q, (exp_own[i] + 1) * 16);
      end
      req = 4'b0000;
      step();
      check("rr_ack_off", ack, 0);
      check("rr_busy_off", busy, 0);

      // Single request on lane 2.
      req = 4'b0100;
      set_lane(2, 8'hA5);
      push(2, 8'hA5);
      step();
      check("one_gnt", gnt, 4'b0100);
      check("one_owner", owner, 2);
      check("one_busy", busy, 1);
      check("one_ack_pre", ack, 0);
      step();
      check("one_gnt_off", gnt, 0);
      check("one_busy_off", busy, 0);
      check("one_q", q, 8'hA5);
      check("one_ack", ack, 1);
      req = 4'b0000;
      step();
      check("one_ack_off", ack, 0);
      check("one_q_hold", q, 8'hA5);
      check("one_owner_hold", owner, 2);

      // Cancel: owner drops its request while granted.
      req = 4'b0010;
      set_lane(1, 8'h5C);
      step();
      check("cxl_gnt", gnt, 4'b0010);
      check("cxl_owner", owner, 1);
      req = 4'b0000;
      step();
      check("cxl_ack", ack, 0);
      check("cxl_q", q, 8'hA5);
      check("cxl_busy", busy, 0);
      check("cxl_gnt_off", gnt, 0);
      req = 4'b0011;
      set_lane(0, 8'h66);
      set_lane(1, 8'h77);
      push(0, 8'h66);
      step();
      check("wrap_gnt", gnt, 4'b0001);
      check("wrap_owner", owner, 0);
      step();
      check("wrap_q", q, 8'h66);
      req = 4'b0000;
      step();

      // Reset mid-grant clears everything before the next edge.
      req = 4'b1000;
      set_lane(3, 8'h99);
      step();
      check("mid_gnt", gnt, 4'b1000);
      #8;
      reset = 1'b1;
      #1;
      check("mid_gnt_clr", gnt, 0);
      check("mid_busy_clr", busy, 0);
      check("mid_q_clr", q, 0);
      check("mid_ack_clr", ack, 0);
      check("mid_owner_clr", owner, 0);
      @(posedge ck);
      #5;
      req   = 4'b0000;
      reset = 1'b0;
      step();
      check("mid_post_q", q, 0);
      check("mid_post_ack", ack, 0);
      check("mid_post_busy", busy, 0);
`endif

      step();
      check("sb_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
